conv_scan_ctrl: RTL and testbench

Raster-scan sequencer for the 3x3 zero-padded window fetcher (`storing_reg`) in the 128x128 image pipeline. On `go` it walks every output pixel of the frame in raster order. For each pixel it drives the fetcher's `start`/`start_addr`, waits for `finish`, and flags the one cycle in which the nine window values are valid for the downstream convolution/write stage. It applies back-pressure from that stage and reports frame completion.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/scan_counter.sv | 61 ++++++
 rtl/conv_scan_ctrl.sv | 110 +++++++++++
 tb/tb_conv_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encodings and image/fetcher constants
// for the 3x3 window scan path.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int IMG_ROW_BITS = 7;
    localparam int IMG_COL_BITS = 7;
    localparam int IMG_ROWS     = 1 << IMG_ROW_BITS;
    localparam int IMG_COLS     = 1 << IMG_COL_BITS;

    // Fetcher start->finish latency in cycles.
    localparam int WIN_LAT = 10;

endpackage

// File: rtl/scan_counter.sv
// scan_counter: raster row/col counter with clear, enable, stride
// and last-pixel flag; shared with the write-back address generator.
module scan_counter
    import conv_pkg::*;
#(
    parameter int ROW_BITS = IMG_ROW_BITS,
    parameter int COL_BITS = IMG_COL_BITS,
    parameter int STRIDE   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    output logic [ROW_BITS-1:0] row_o,
    output logic [COL_BITS-1:0] col_o,
    output logic                last_o
);

    localparam logic [ROW_BITS-1:0] ROW_STEP = ROW_BITS'(STRIDE);
    localparam logic [COL_BITS-1:0] COL_STEP = COL_BITS'(STRIDE);
    localparam logic [ROW_BITS-1:0] ROW_LAST =
        ROW_BITS'((1 << ROW_BITS) - STRIDE);
    localparam logic [COL_BITS-1:0] COL_LAST =
        COL_BITS'((1 << COL_BITS) - STRIDE);

    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                col_wrap;

    assign col_wrap = (col_q == COL_LAST);
    assign last_o   = col_wrap && (row_q == ROW_LAST);
    assign row_o    = row_q;
    assign col_o    = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ROW_STEP;
            end else begin
                col_d = col_q + COL_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: raster-scan sequencer driving the 3x3 window fetcher.
// Define SCAN_STRIDE2_EN for stride-2 (pooling) scanning.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int ROW_BITS = IMG_ROW_BITS,
    parameter int COL_BITS = IMG_COL_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    output logic                         win_start,
    output logic [ROW_BITS+COL_BITS-1:0] win_addr,
    input  logic                         win_finish,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ROW_BITS+COL_BITS-1:0] res_addr,
    output logic                         busy,
    output logic                         done
);

`ifdef SCAN_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    state_t state_q, state_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_last;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;

    scan_counter #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .STRIDE   (STRIDE)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .row_o  (row),
        .col_o  (col),
        .last_o (cnt_last)
    );

    assign win_addr = {row, col};

`ifdef SCAN_STRIDE2_EN
    logic unused_lsb;
    assign unused_lsb = row[0] ^ col[0];
    assign res_addr   = {2'b00, row[ROW_BITS-1:1], col[COL_BITS-1:1]};
`else
    assign res_addr = win_addr;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter only moves on WAIT->ISSUE so the fetcher sees a stable address.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        win_start = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    cnt_clr = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (res_ready) begin
                    win_start = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (win_finish) begin
                    res_valid = 1'b1;
                    if (cnt_last) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_en  = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// tb_conv_scan_ctrl: scoreboard bench with a behavioural fetcher
// and randomized back-pressure / spurious inputs.
module tb_conv_scan_ctrl;
    import conv_pkg::*;

    localparam int RB = 2;
    localparam int CB = 3;
    localparam int AW = RB + CB;
    localparam int H  = 1 << RB;
    localparam int W  = 1 << CB;
`ifdef SCAN_STRIDE2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int NPIX = (H / STEP) * (W / STEP);
    localparam int TGT  = (STEP == 1) ? (3 * W + 5) : (2 * W + 4);

    typedef struct {
        logic [AW-1:0] w;
        logic [AW-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic go = 1'b0;
    logic res_ready = 1'b0;
    logic inj = 1'b0;
    logic win_start, win_finish, res_valid, busy, done;
    logic [AW-1:0] win_addr, res_addr;
    int fcnt = 0;

    always #5 clk = ~clk;

    conv_scan_ctrl #(.ROW_BITS(RB), .COL_BITS(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .win_start  (win_start),
        .win_addr   (win_addr),
        .win_finish (win_finish),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_addr   (res_addr),
        .busy       (busy),
        .done       (done)
    );

    // Fetcher: finish in the 10th cycle after the edge that took start.
    assign win_finish = (fcnt == 1) || inj;
    always @(posedge clk) begin
        if (fcnt > 0) fcnt <= fcnt - 1;
        else if (win_start) fcnt <= WIN_LAT;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;
    exp_t q[$];
    int valid_cyc[$];
    int start_cyc[$];
    logic [AW-1:0] start_addr[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void push_frame();
        exp_t e;
        for (int r = 0; r < H; r += STEP)
            for (int c = 0; c < W; c += STEP) begin
                e.w = AW'(r * W + c);
                e.r = AW'((r / STEP) * (W / STEP) + (c / STEP));
                q.push_back(e);
            end
    endfunction

    // Protocol tracker: a pending issue, an outstanding window, a done pulse.
    bit m_iss = 0, m_out = 0, m_done = 0;
    bit e_busy, e_start, e_valid, n_iss, n_out, n_done;

    always @(negedge clk) begin
        cyc++;
        e_busy  = m_iss | m_out | m_done;
        e_start = m_iss && res_ready;
        e_valid = m_out && win_finish;
        n_iss = m_iss;
        n_out = m_out;
        n_done = 1'b0;
        chk("busy", busy, e_busy);
        chk("done", done, m_done);
        chk("win_start", win_start, e_start);
        chk("res_valid", res_valid, e_valid);
        if (res_valid) valid_cyc.push_back(cyc);
        if (win_start) begin
            start_cyc.push_back(cyc);
            start_addr.push_back(win_addr);
        end
        if (done) done_cyc = cyc;
        if ((m_iss || m_out) && q.size() > 0)
            chk("win_addr", win_addr, q[0].w);
        if (e_valid && q.size() > 0) begin
            chk("res_addr", res_addr, q[0].r);
            void'(q.pop_front());
        end
        if (!rst) begin
            n_iss = 0;
            n_out = 0;
            q.delete();
        end else begin
            if (!e_busy && go) begin
                n_iss = 1;
                push_frame();
            end
            if (e_start) begin
                n_iss = 0;
                n_out = 1;
            end
            if (e_valid) begin
                n_out = 0;
                if (q.size() == 0) n_done = 1;
                else n_iss = 1;
            end
        end
        m_iss = n_iss;
        m_out = n_out;
        m_done = n_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_win_start"}, win_start, 0);
        chk({tag, "_win_addr"}, win_addr, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_addr"}, res_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic clear_logs();
        valid_cyc.delete();
        start_cyc.delete();
        start_addr.delete();
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            if (rnd) begin
                res_ready = ($urandom_range(0, 99) < 65);
                go = ($urandom_range(0, 19) == 0);
                inj = (fcnt == 0) && ($urandom_range(0, 9) == 0);
            end
            @(negedge clk);
            seen = done;
            n++;
            @(posedge clk);
            #1;
        end
        go = 0;
        inj = 0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_timeout: no done within %0d cycles", budget);
        end
        tick(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_cyc;
        int n;
        bit seen;
        tick(3);
        chk_zero("reset");
        rst = 1;
        tick(2);

        // Directed frame: 5-cycle stall before pixel 2.
        clear_logs();
        res_ready = 1;
        go = 1;
        tick(1);
        go = 0;
        go_cyc = cyc;
        n = 0;
        while (valid_cyc.size() < 2 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        res_ready = 0;
        tick(5);
        res_ready = 1;
        wait_done(2000, 0);
        chk("npix_a", valid_cyc.size(), NPIX);
        if (valid_cyc.size() == NPIX && start_cyc.size() == NPIX) begin
            chk("first_valid_lat", valid_cyc[0] - go_cyc, 11);
            chk("pix_period", valid_cyc[1] - valid_cyc[0], 11);
            chk("stall_delay", start_cyc[2] - valid_cyc[1], 6);
            chk("stall_addr", start_addr[2], AW'(2 * STEP));
            chk("pix3_period", valid_cyc[3] - valid_cyc[2], 11);
            chk("done_lat", done_cyc - valid_cyc[NPIX-1], 1);
        end

        // Random frames with spurious go / finish.
        for (int f = 0; f < 3; f++) begin
            clear_logs();
            go = 1;
            tick(1);
            go = 0;
            wait_done(4000, 1);
            chk("npix_rand", valid_cyc.size(), NPIX);
        end

        // Mid-frame reset during WAIT at the target pixel.
        clear_logs();
        res_ready = 1;
        go = 1;
        tick(1);
        go = 0;
        n = 0;
        seen = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            seen = win_start && (win_addr == AW'(TGT));
            n++;
        end
        chk("reach_target", seen, 1);
        @(posedge clk);
        #1;
        tick(2);
        rst = 0;
        tick(1);
        rst = 1;
        chk_zero("midreset");
        valid_cyc.delete();
        n = 0;
        while (fcnt != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        tick(2);
        chk("late_finish_valid", valid_cyc.size(), 0);

        clear_logs();
        go = 1;
        tick(1);
        go = 0;
        wait_done(2000, 0);
        chk("npix_restart", valid_cyc.size(), NPIX);
        if (start_addr.size() > 0)
            chk("restart_addr", start_addr[0], 0);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
